// File: rtl/sha256_host_pkg.sv
// Shared constants and state type for the SHA-256 host-side initiator.
// Command codes match the core's cmd_i encoding.
package sha256_host_pkg;

  localparam logic [2:0] CMD_START_FIRST = 3'b010;
  localparam logic [2:0] CMD_START_NEXT  = 3'b110;
  localparam logic [2:0] CMD_READ        = 3'b001;

  localparam int WORDS_PER_BLOCK = 16;
  localparam int DIGEST_WORDS    = 8;

  localparam logic [3:0] LAST_WORD_IDX   = 4'(WORDS_PER_BLOCK - 1);
  localparam logic [3:0] LAST_DIGEST_IDX = 4'(DIGEST_WORDS - 1);
  // The core raises busy within two cycles of the last text word.
  localparam logic [3:0] WAIT_MIN_CYCLES = 4'd2;

  typedef enum logic [2:0] {
    ST_FILL  = 3'd0,
    ST_START = 3'd1,
    ST_SEND  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RDCMD = 3'd4,
    ST_READ  = 3'd5,
    ST_DONE  = 3'd6
  } host_state_e;

endpackage

// File: rtl/sha256_block_buf.sv
// 16 x 32-bit message block buffer: one synchronous write port and one
// combinational read port.
module sha256_block_buf (
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  raddr,
  output logic [31:0] rdata
);

  logic [31:0] r_mem [16];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/sha256_host_ctrl.sv
// Host-side initiator for the SHA-256 core: buffers one 512-bit block, issues
// start, streams the words, waits on busy and reads back the 256-bit digest.
module sha256_host_ctrl
  import sha256_host_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  msg_data_i,
  input  logic         msg_valid_i,
  output logic         msg_ready_o,
  input  logic         msg_first_i,
  input  logic         msg_last_i,
  output logic [255:0] digest_o,
  output logic         digest_valid_o,
  input  logic         digest_ready_i,
  output logic [31:0]  core_text_o,
  output logic [2:0]   core_cmd_o,
  output logic         core_cmd_w_o,
  input  logic [31:0]  core_text_i,
  input  logic         core_busy_i
);

  // Handshakes: a message word transfers on any rising edge where
  // msg_valid_i && msg_ready_o; the digest transfers on any rising edge where
  // digest_valid_o && digest_ready_i. Valid, once raised, is held until taken.

  host_state_e r_state;
  host_state_e w_next_state;

  // Shared counter: word index in FILL/SEND/READ, elapsed cycles in WAIT.
  logic [3:0]   r_cnt;
  logic [3:0]   w_next_cnt;
  logic         r_first;
  logic         r_last;
  logic [255:0] r_digest;

  logic         w_ready;
  logic         w_cmd_w;
  logic [2:0]   w_cmd;
  logic [31:0]  w_text;
  logic         w_dvalid;
  logic         w_accept;
  logic [31:0]  w_buf_rdata;

  sha256_block_buf u_buf (
    .clk   (clk),
    .we    (w_accept),
    .waddr (r_cnt),
    .wdata (msg_data_i),
    .raddr (r_cnt),
    .rdata (w_buf_rdata)
  );

  assign w_accept = msg_valid_i & msg_ready_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_FILL;
      r_cnt    <= '0;
      r_first  <= 1'b0;
      r_last   <= 1'b0;
      r_digest <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_accept && (r_cnt == 4'd0)) begin
        r_first <= msg_first_i;
        r_last  <= msg_last_i;
      end
      if (r_state == ST_READ) begin
        for (int k = 0; k < DIGEST_WORDS; k++) begin
          if (r_cnt == 4'(k)) begin
            r_digest[255 - 32*k -: 32] <= core_text_i;
          end
        end
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_ready      = 1'b0;
    w_cmd_w      = 1'b0;
    w_cmd        = 3'b000;
    w_text       = '0;
    w_dvalid     = 1'b0;

    case (r_state)
      ST_FILL: begin
        w_ready = 1'b1;
        if (msg_valid_i) begin
          if (r_cnt == LAST_WORD_IDX) begin
            w_next_state = ST_START;
            w_next_cnt   = '0;
          end else begin
            w_next_cnt = r_cnt + 4'd1;
          end
        end
      end

      ST_START: begin
        w_cmd_w      = 1'b1;
        w_cmd        = r_first ? CMD_START_FIRST : CMD_START_NEXT;
        w_next_state = ST_SEND;
      end

      ST_SEND: begin
        w_text = w_buf_rdata;
        if (r_cnt == LAST_WORD_IDX) begin
          w_next_state = ST_WAIT;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + 4'd1;
        end
      end

      // Busy is not trusted until the core has had time to raise it.
      ST_WAIT: begin
        if (r_cnt < WAIT_MIN_CYCLES) begin
          w_next_cnt = r_cnt + 4'd1;
        end else if (!core_busy_i) begin
          w_next_state = r_last ? ST_RDCMD : ST_FILL;
          w_next_cnt   = '0;
        end
      end

      ST_RDCMD: begin
        w_cmd_w      = 1'b1;
        w_cmd        = CMD_READ;
        w_next_state = ST_READ;
        w_next_cnt   = '0;
      end

      ST_READ: begin
        if (r_cnt == LAST_DIGEST_IDX) begin
          w_next_state = ST_DONE;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + 4'd1;
        end
      end

      ST_DONE: begin
        w_dvalid = 1'b1;
        if (digest_ready_i) begin
          w_next_state = ST_FILL;
        end
      end

      default: begin
        w_next_state = ST_FILL;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Outputs are forced low for the whole of any reset cycle.
  assign msg_ready_o    = w_ready & ~reset;
  assign core_cmd_w_o   = w_cmd_w & ~reset;
  assign core_cmd_o     = reset ? 3'b000 : w_cmd;
  assign core_text_o    = reset ? 32'd0 : w_text;
  assign digest_valid_o = w_dvalid & ~reset;
  assign digest_o       = reset ? 256'd0 : r_digest;

endmodule

// File: tb/tb_sha256_host_ctrl.sv
// Bench for sha256_host_ctrl: a transaction-level SHA-256 core responder plus
// a message driver, checked against a plain-arithmetic SHA-256 reference.
module tb_sha256_host_ctrl;
  import sha256_host_pkg::*;

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIGEST = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  msg_data_i = '0;
  logic         msg_valid_i = 1'b0;
  logic         msg_ready_o;
  logic         msg_first_i = 1'b0;
  logic         msg_last_i = 1'b0;
  logic [255:0] digest_o;
  logic         digest_valid_o;
  logic         digest_ready_i = 1'b0;
  logic [31:0]  core_text_o;
  logic [2:0]   core_cmd_o;
  logic         core_cmd_w_o;
  logic [31:0]  core_text_i = '0;
  logic         core_busy_i = 1'b0;

  always #5 clk = ~clk;

  sha256_host_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .msg_data_i     (msg_data_i),
    .msg_valid_i    (msg_valid_i),
    .msg_ready_o    (msg_ready_o),
    .msg_first_i    (msg_first_i),
    .msg_last_i     (msg_last_i),
    .digest_o       (digest_o),
    .digest_valid_o (digest_valid_o),
    .digest_ready_i (digest_ready_i),
    .core_text_o    (core_text_o),
    .core_cmd_o     (core_cmd_o),
    .core_cmd_w_o   (core_cmd_w_o),
    .core_text_i    (core_text_i),
    .core_busy_i    (core_busy_i)
  );

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0]  exp_word_q[$];
  logic [2:0]   exp_cmd_q[$];
  logic [255:0] exp_dig_q[$];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference SHA-256 ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h_in, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    logic [255:0] v, res;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    {a, b, c, d, e, f, g, h} = h_in;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    v = {a, b, c, d, e, f, g, h};
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = h_in[255 - 32*i -: 32] + v[255 - 32*i -: 32];
    return res;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] blk;
    for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom;
    return blk;
  endfunction

  // ---------------- core responder / monitor ----------------
  logic [255:0] core_h = IV;
  logic [511:0] core_blk = '0;
  int sidx = 16;
  int busy_left = 0;
  int busy_len = 4;
  int rd_idx = 8;
  int cyc = 0;
  int fall_cyc = -100;
  int dv_exp_cyc = -100;
  int viol = 0;
  logic prev_dv = 1'b0;

  always begin
    @(posedge clk); #1;
    cyc++;
    if (reset) begin
      sidx = 16; busy_left = 0; rd_idx = 8; prev_dv = 1'b0;
      core_busy_i = 1'b0; core_text_i = $urandom;
    end else begin
      // drive the core outputs for this cycle
      if (rd_idx < 8) begin
        core_text_i = core_h[255 - 32*rd_idx -: 32];
        rd_idx++;
      end else begin
        core_text_i = $urandom;
      end
      if (busy_left > 0) begin
        core_busy_i = 1'b1;
        busy_left--;
      end else if (core_busy_i) begin
        core_busy_i = 1'b0;
        fall_cyc = cyc;
      end
      // observe the controller
      if (!core_cmd_w_o && core_cmd_o != 3'b000) viol++;
      if (sidx < 16) begin
        check_eq("send_word", 256'(core_text_o), 256'((exp_word_q.size() > 0) ? exp_word_q.pop_front() : 32'd0));
        core_blk[511 - 32*sidx -: 32] = core_text_o;
        sidx++;
        if (sidx == 16) begin
          core_h = sha_compress(core_h, core_blk);
          busy_left = busy_len;
        end
      end else if (core_text_o != 32'd0) begin
        viol++;
      end
      if (core_cmd_w_o) begin
        check_eq("cmd", 256'(core_cmd_o), 256'((exp_cmd_q.size() > 0) ? exp_cmd_q.pop_front() : 3'b000));
        if (core_cmd_o == CMD_START_FIRST || core_cmd_o == CMD_START_NEXT) begin
          if (core_cmd_o == CMD_START_FIRST) core_h = IV;
          sidx = 0;
        end else if (core_cmd_o == CMD_READ) begin
          check_eq("rdcmd_latency", 256'(cyc), 256'(fall_cyc + 1));
          rd_idx = 0;
          dv_exp_cyc = cyc + 9;
        end
      end
      if (digest_valid_o && !prev_dv) begin
        check_eq("digest_latency", 256'(cyc), 256'(dv_exp_cyc));
        check_eq("digest", digest_o, (exp_dig_q.size() > 0) ? exp_dig_q.pop_front() : 256'd0);
      end
      prev_dv = digest_valid_o;
    end
  end

  // ---------------- driver tasks ----------------
  logic [255:0] tb_h = IV;

  task automatic push_word(input logic [31:0] d, input logic f, input logic l, input int stall_pct);
    int guard = 0;
    logic acc = 1'b0;
    while (stall_pct > 0 && int'($urandom_range(99)) < stall_pct) begin
      msg_valid_i = 1'b0; msg_data_i = $urandom;
      @(posedge clk); #2;
    end
    msg_valid_i = 1'b1; msg_data_i = d; msg_first_i = f; msg_last_i = l;
    while (!acc && guard < 1000) begin
      acc = msg_ready_o;
      @(posedge clk); #2;
      guard++;
    end
    if (!acc) check_eq("msg_accept_timeout", 256'(acc), 256'(1));
  endtask

  task automatic run_block(input logic [511:0] blk, input logic first, input logic last, input int stall_pct);
    for (int i = 0; i < 16; i++) exp_word_q.push_back(blk[511 - 32*i -: 32]);
    exp_cmd_q.push_back(first ? CMD_START_FIRST : CMD_START_NEXT);
    if (last) exp_cmd_q.push_back(CMD_READ);
    if (first) tb_h = IV;
    tb_h = sha_compress(tb_h, blk);
    if (last) exp_dig_q.push_back(tb_h);
    for (int i = 0; i < 16; i++)
      push_word(blk[511 - 32*i -: 32], (i == 0) ? first : 1'($urandom), (i == 0) ? last : 1'($urandom), stall_pct);
    msg_valid_i = 1'b0;
  endtask

  task automatic wait_digest(input int hold, output logic [255:0] d);
    int guard = 0;
    logic stable;
    digest_ready_i = (hold == 0);
    while (!digest_valid_o && guard < 2000) begin
      @(posedge clk); #2;
      guard++;
    end
    if (!digest_valid_o) begin
      check_eq("digest_timeout", 256'(digest_valid_o), 256'(1));
      digest_ready_i = 1'b0;
      d = '0;
      return;
    end
    d = digest_o;
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(posedge clk); #2;
        if (!digest_valid_o || digest_o !== d || msg_ready_o) stable = 1'b0;
      end
      check_eq("digest_hold_stable", 256'(stable), 256'(1));
      digest_ready_i = 1'b1;
    end
    @(posedge clk); #2;
    digest_ready_i = 1'b0;
    check_eq("post_handshake_valid", 256'(digest_valid_o), 256'(0));
    check_eq("post_handshake_ready", 256'(msg_ready_o), 256'(1));
    check_eq("digest_kept", digest_o, d);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_msg_ready"}, 256'(msg_ready_o), 256'(0));
    check_eq({tag, "_digest_valid"}, 256'(digest_valid_o), 256'(0));
    check_eq({tag, "_digest"}, digest_o, 256'(0));
    check_eq({tag, "_core_text"}, 256'(core_text_o), 256'(0));
    check_eq({tag, "_core_cmd"}, 256'(core_cmd_o), 256'(0));
    check_eq({tag, "_core_cmd_w"}, 256'(core_cmd_w_o), 256'(0));
  endtask

  // ---------------- stimulus ----------------
  logic [511:0] abc_blk;
  logic [255:0] got_d;

  initial begin
    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0] = 32'h00000018;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_outputs_zero("reset");
    reset = 1'b0;
    @(posedge clk); #2;
    check_eq("ready_after_reset", 256'(msg_ready_o), 256'(1));

    // single-block "abc", same-cycle digest handshake
    busy_len = 5;
    run_block(abc_blk, 1'b1, 1'b1, 0);
    wait_digest(0, got_d);
    check_eq("abc_digest", got_d, ABC_DIGEST);

    // two-block message, consumer stalls 20 cycles
    busy_len = int'($urandom_range(3, 12));
    run_block(rand_block(), 1'b1, 1'b0, 0);
    run_block(rand_block(), 1'b0, 1'b1, 0);
    wait_digest(20, got_d);

    // random upstream stalls, multi-block messages
    for (int m = 0; m < 4; m++) begin
      int nblk = int'($urandom_range(1, 3));
      for (int b = 0; b < nblk; b++) begin
        busy_len = int'($urandom_range(3, 12));
        run_block(rand_block(), (b == 0), (b == nblk - 1), 50);
      end
      wait_digest(int'($urandom_range(0, 3)), got_d);
    end

    // long busy from the core
    busy_len = 80;
    run_block(rand_block(), 1'b1, 1'b1, 0);
    wait_digest(0, got_d);
    busy_len = 4;

    // non-first block with no preceding first block of its own
    run_block(rand_block(), 1'b0, 1'b1, 0);
    wait_digest(1, got_d);

    // reset while word 7 is on the core bus
    run_block(rand_block(), 1'b1, 1'b1, 0);
    for (int g = 0; g < 200 && sidx != 8; g++) begin
      @(posedge clk); #2;
    end
    check_eq("reached_send_word7", 256'(sidx), 256'(8));
    reset = 1'b1;
    @(posedge clk); #2;
    check_outputs_zero("mid_send_reset");
    exp_word_q.delete();
    exp_cmd_q.delete();
    exp_dig_q.delete();
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;
    check_eq("ready_after_mid_reset", 256'(msg_ready_o), 256'(1));
    run_block(abc_blk, 1'b1, 1'b1, 25);
    wait_digest(2, got_d);
    check_eq("abc_digest_after_reset", got_d, ABC_DIGEST);

    repeat (5) @(posedge clk);
    #2;
    check_eq("idle_cmd_and_text_zero", 256'(viol), 256'(0));
    check_eq("cmd_queue_drained", 256'(exp_cmd_q.size()), 256'(0));
    check_eq("word_queue_drained", 256'(exp_word_q.size()), 256'(0));
    check_eq("digest_queue_drained", 256'(exp_dig_q.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_host_ctrl.md
# sha256_host_ctrl

Host-side initiator for the SHA-256 core's 32-bit word/command interface. It accepts message words on a valid/ready stream and buffers one 512-bit block. It then issues the start command and streams the 16 words to the core. It waits on the core's busy flag and, after the final block of a message, issues the read command and assembles the 256-bit digest. It sits between the testbench/system host and the core, which acts as the responder.

## Interface
- Parameters: none. Block size is 16 words and digest size is 8 words, both fixed package constants.
- `clk` in 1: single clock; everything is sampled on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `msg_data_i` in 32: message word, pre-padded by the host.
- `msg_valid_i` in 1: `msg_data_i` is valid.
- `msg_ready_o` out 1: block accepts a word; a transfer occurs when valid && ready.
- `msg_first_i` in 1: sampled with word 0 of a block; 1 = first block of a message (core loads IV).
- `msg_last_i` in 1: sampled with word 0 of a block; 1 = final block of the message (read digest afterwards).
- `digest_o` out 256: digest; `[255:224]` = first word read (H0).
- `digest_valid_o` out 1: digest is held; stays high until `digest_ready_i`.
- `digest_ready_i` in 1: consumer takes the digest.
- `core_text_o` out 32: drives the core's `text_i`.
- `core_cmd_o` out 3: drives the core's `cmd_i`.
- `core_cmd_w_o` out 1: one-cycle command write strobe (core's `cmd_w_i`).
- `core_text_i` in 32: driven by the core's `text_o`.
- `core_busy_i` in 1: driven by the core's `cmd_o` (high while hashing).

## Operation
- Command codes:
  - `CMD_START_FIRST = 3'b010`
  - `CMD_START_NEXT = 3'b110`
  - `CMD_READ = 3'b001`
  - `core_cmd_o` = 0 whenever `core_cmd_w_o` = 0.
- FSM states: FILL, START, SEND, WAIT, RDCMD, READ, DONE. FILL is the reset state.
- FILL:
  - `msg_ready_o` = 1.
  - Each accepted word is written to `buf[wcnt]`; `wcnt` counts 0..15.
  - `first`/`last` flags are latched on word 0 only.
  - On acceptance of word 15 -> START.
- START:
  - `core_cmd_w_o` = 1 for exactly one cycle.
  - `core_cmd_o` = `CMD_START_FIRST` if the latched first flag is set, else `CMD_START_NEXT`.
  - -> SEND.
- SEND:
  - 16 consecutive cycles with `core_text_o` = `buf[0..15]`, no gaps.
  - -> WAIT.
- WAIT:
  - Minimum 2 cycles (the core raises busy within 2 cycles of the last word).
  - Leaves on the first cycle after the minimum in which `core_busy_i` = 0.
  - -> RDCMD if the latched last flag is set, else -> FILL.
- RDCMD:
  - One-cycle `core_cmd_w_o` with `CMD_READ`.
  - -> READ.
- READ:
  - 8 consecutive cycles starting the cycle after RDCMD.
  - Word k of `core_text_i` is captured into `digest_o[255-32k -: 32]`.
  - -> DONE.
- DONE:
  - `digest_valid_o` = 1 and `digest_o` held stable.
  - `msg_ready_o` = 0.
  - On `digest_ready_i` = 1 -> FILL. The digest register keeps its value until the next READ.
- `core_text_o` = 0 outside SEND.
- `core_busy_i` is ignored outside WAIT.
- A non-first block arriving with no prior first block is forwarded as `CMD_START_NEXT`. Sequencing is the host's responsibility; the block raises no error.

## Timing
- Reset values (held during any reset cycle): all outputs 0, state = FILL, counters = 0, digest register = 0.
- `msg_ready_o` goes to 1 on the first cycle after reset deasserts.
- Reset mid-operation aborts immediately:
  - No further `core_cmd_w_o`.
  - Buffer contents are don't-care.
  - `digest_valid_o` drops in the same cycle reset is sampled.
- Latency, from the accept of word 15 to the START strobe: 1 cycle.
- Latency, from START to the first SEND word: 1 cycle.
- Latency, from busy falling (observed in WAIT) to the RDCMD strobe: 1 cycle.
- Latency, from RDCMD to `digest_valid_o`: 9 cycles.
- Upstream stalls (`msg_valid_i` = 0) are allowed only in FILL; the core never sees gaps.
- `digest_valid_o` and `digest_ready_i` may both be high on the same cycle DONE is entered: the handshake completes and the next cycle is FILL.

## Structure
- `sha256_host_pkg`:
  - The three command localparams.
  - `WORDS_PER_BLOCK` = 16, `DIGEST_WORDS` = 8.
  - `typedef enum logic [2:0]` for the state.
- Sub-module `sha256_block_buf`: 16x32 register file with write port (`we`, `waddr[3:0]`) and combinational read (`raddr[3:0]`).
- The FSM and counters live in `sha256_host_ctrl`.

## Test plan
- Single block "abc": stream `61626380`, 14x `00000000`, `00000018` with first=last=1 -> one `CMD_START_FIRST` strobe, 16 gap-free words, `CMD_READ`. Digest = `ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad`.
- Two-block message, first=1/last=0 then first=0/last=1 -> commands `010`, `110`, `001` in order. No read after block 1; digest matches the reference model.
- Random `msg_valid_i` stalls (50%) in FILL -> SEND still 16 consecutive cycles with identical word order.
- `core_busy_i` held high 80 cycles -> `core_cmd_w_o` stays 0 until 1 cycle after busy falls.
- `digest_ready_i` held low 20 cycles -> `digest_valid_o` and `digest_o` stable, `msg_ready_o` = 0 throughout.
- Reset asserted mid-SEND (word 7) -> next cycle all outputs 0. After release, a fresh "abc" block produces the correct digest.
